// File: rtl/oq_port_merge_2_if.sv
// rtl/oq_port_merge_2_if.sv - word stream with write strobe and ready for the oq port merger
interface oq_port_merge_2_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] data;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic                  wr;
   logic                  rdy;

   modport master (output data, output ctrl, output wr, input rdy);
   modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/oq_port_merge_2.sv
// rtl/oq_port_merge_2.sv - packet-granular round-robin merge of two output queue ports
module oq_port_merge_2 #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH_BITS = 3,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   oq_port_merge_2_if.slave     in_0,
   oq_port_merge_2_if.slave     in_1,
   oq_port_merge_2_if.master    out,
   output logic [CNT_WIDTH-1:0] pkt_cnt_0,
   output logic [CNT_WIDTH-1:0] pkt_cnt_1
);
   localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
   localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0] FIFO_FULL = (FIFO_DEPTH_BITS + 1)'(DEPTH);
   localparam logic [FIFO_DEPTH_BITS:0] RDY_MAX   = (FIFO_DEPTH_BITS + 1)'(DEPTH - 2);

   typedef enum logic [1:0] {IDLE, SEND_0, SEND_1} state_t;

   state_t               state, state_nxt;
   logic                 last_port;
   logic [1:0]           in_payload;
   logic [1:0]           wr_en, fifo_rdy, not_empty, eop, pop;
   logic [WORD_W-1:0]    wr_word [2];
   logic [WORD_W-1:0]    head [2];
   logic [CNT_WIDTH-1:0] cnt [2];

   assign wr_word[0] = {in_0.ctrl, in_0.data};
   assign wr_word[1] = {in_1.ctrl, in_1.data};
   assign wr_en      = {in_1.wr, in_0.wr};
   assign in_0.rdy   = fifo_rdy[0];
   assign in_1.rdy   = fifo_rdy[1];
   assign pkt_cnt_0  = cnt[0];
   assign pkt_cnt_1  = cnt[1];

   // Per-port fallthrough FIFO: head word is visible whenever count is non-zero
   for (genvar p = 0; p < 2; p++) begin : g_fifo
      logic [WORD_W-1:0]          mem [DEPTH];
      logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
      logic [FIFO_DEPTH_BITS:0]   count;
      logic                       push;

      assign push         = wr_en[p] && (count != FIFO_FULL);
      assign head[p]      = mem[rd_ptr];
      assign not_empty[p] = (count != '0);
      assign fifo_rdy[p]  = (count <= RDY_MAX);

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= wr_word[p];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop[p]) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop[p]})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   always_comb begin
      eop[0] = (head[0][DATA_WIDTH +: CTRL_WIDTH] != '0) && in_payload[0];
      eop[1] = (head[1][DATA_WIDTH +: CTRL_WIDTH] != '0) && in_payload[1];
   end

   always_comb begin
      state_nxt = state;
      pop       = 2'b00;
      case (state)
         IDLE: begin
            if (not_empty[0] && not_empty[1]) state_nxt = last_port ? SEND_0 : SEND_1;
            else if (not_empty[0])            state_nxt = SEND_0;
            else if (not_empty[1])            state_nxt = SEND_1;
         end
         SEND_0: begin
            pop[0] = out.rdy && not_empty[0];
            if (pop[0] && eop[0]) state_nxt = IDLE;
         end
         SEND_1: begin
            pop[1] = out.rdy && not_empty[1];
            if (pop[1] && eop[1]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_port  <= 1'b1;
         in_payload <= 2'b00;
         out.wr     <= 1'b0;
         out.data   <= '0;
         out.ctrl   <= '0;
         cnt[0]     <= '0;
         cnt[1]     <= '0;
      end else begin
         state  <= state_nxt;
         out.wr <= |pop;
         if (|pop) {out.ctrl, out.data} <= pop[1] ? head[1] : head[0];
         // A non-zero ctrl word only closes a packet once payload has been seen
         for (int p = 0; p < 2; p++) begin
            if (pop[p]) begin
               if (head[p][DATA_WIDTH +: CTRL_WIDTH] == '0) begin
                  in_payload[p] <= 1'b1;
               end else if (in_payload[p]) begin
                  in_payload[p] <= 1'b0;
                  cnt[p]        <= cnt[p] + 1'b1;
                  last_port     <= (p == 1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_oq_port_merge_2.sv
// tb/tb_oq_port_merge_2.sv - scoreboard bench for oq_port_merge_2
module tb_oq_port_merge_2;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pkt_cnt_0, pkt_cnt_1;

   oq_port_merge_2_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) if_0 ();
   oq_port_merge_2_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) if_1 ();
   oq_port_merge_2_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) if_out ();

   oq_port_merge_2 dut (
      .clk(clk), .reset(reset), .in_0(if_0), .in_1(if_1), .out(if_out),
      .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          seq [2] = '{0, 0};
   int          exp_cnt [2] = '{0, 0};
   logic [71:0] exp_q0 [$];
   logic [71:0] exp_q1 [$];
   int          order_log [$];
   int          cyc_log [$];
   bit          rand_done;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic port_rdy(input int p);
      return (p == 0) ? if_0.rdy : if_1.rdy;
   endfunction

   task automatic drive(input int p, input logic wr, input logic [7:0] c, input logic [63:0] d);
      if (p == 0) begin if_0.wr = wr; if_0.ctrl = c; if_0.data = d; end
      else        begin if_1.wr = wr; if_1.ctrl = c; if_1.data = d; end
   endtask

   task automatic push_exp(input int p, input logic [7:0] c, input logic [63:0] d);
      if (p == 0) exp_q0.push_back({c, d});
      else        exp_q1.push_back({c, d});
   endtask

   // Called at a negedge; each word is presented for one edge once the port is ready
   task automatic send_pkt(input int p, input int nhdr, input int npay, input int stall_at,
                           input int stall_len, input logic [7:0] last_c);
      int n;
      n = nhdr + npay + 1;
      for (int i = 0; i < n; i++) begin
         logic [7:0]  c;
         logic [63:0] d;
         int          budget;
         if (i < nhdr)             c = 8'hFF;
         else if (i < nhdr + npay) c = 8'h00;
         else if (last_c != 0)     c = last_c;
         else                      c = 8'($urandom_range(1, 255));
         d = {p[0], seq[p][14:0], 16'(i), 32'($urandom())};
         if (i == stall_at) begin
            drive(p, 1'b0, 8'h00, 64'h0);
            repeat (stall_len) @(negedge clk);
         end
         budget = 0;
         while (!port_rdy(p) && budget < 1000) begin
            drive(p, 1'b0, 8'h00, 64'h0);
            @(negedge clk);
            budget++;
         end
         if (budget >= 1000) begin
            checks++; errors++;
            $display("FAIL rdy_wait port %0d got rdy=0 expected 1", p);
         end
         drive(p, 1'b1, c, d);
         push_exp(p, c, d);
         @(negedge clk);
      end
      drive(p, 1'b0, 8'h00, 64'h0);
      seq[p]++;
      exp_cnt[p]++;
   endtask

   task automatic drain(input string name);
      int b;
      b = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && b < 2000) begin
         @(negedge clk);
         b++;
      end
      check({name, "_drain_left"}, 72'(exp_q0.size() + exp_q1.size()), 72'd0);
      repeat (3) @(negedge clk);
      check({name, "_cnt0"}, 72'(pkt_cnt_0), 72'(exp_cnt[0]));
      check({name, "_cnt1"}, 72'(pkt_cnt_1), 72'(exp_cnt[1]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1'b0, 8'h00, 64'h0);
      drive(1, 1'b0, 8'h00, 64'h0);
      exp_q0.delete();
      exp_q1.delete();
      order_log.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
   endtask

   // Monitor: pops the granted port's expected word whenever the merged stream writes
   initial begin : monitor
      bit          active;
      bit          seen_pay;
      int          cur;
      logic [71:0] got;
      logic [71:0] exp;
      int          p;
      active = 0; seen_pay = 0; cur = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            active = 0; seen_pay = 0;
            continue;
         end
         if (!if_out.wr) continue;
         got = {if_out.ctrl, if_out.data};
         p   = int'(if_out.data[63]);
         cyc_log.push_back(cyc);
         check("rdy_at_pop", 72'(if_out.rdy), 72'd1);
         if (active && p != cur) begin
            checks++; errors++;
            $display("FAIL interleave got port %0d expected port %0d", p, cur);
         end
         if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL spurious_word got %0h expected none", got);
            continue;
         end
         exp = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check("out_word", got, exp);
         if (!active) begin active = 1; cur = p; end
         if (got[71:64] == 8'h00) seen_pay = 1;
         else if (seen_pay) begin
            order_log.push_back(p);
            active = 0; seen_pay = 0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k0;
      drive(0, 1'b0, 8'h00, 64'h0);
      drive(1, 1'b0, 8'h00, 64'h0);
      if_out.rdy = 1'b1;
      do_reset();

      // Reset state
      check("rst_out_wr", 72'(if_out.wr), 72'd0);
      check("rst_out_data", 72'({if_out.ctrl, if_out.data}), 72'd0);
      check("rst_rdy0", 72'(if_0.rdy), 72'd1);
      check("rst_rdy1", 72'(if_1.rdy), 72'd1);
      check("rst_cnt0", 72'(pkt_cnt_0), 72'd0);

      // T1: single 4-word packet, latency and back-to-back output
      cyc_log.delete();
      k0 = cyc;
      send_pkt(0, 1, 2, 99, 0, 8'h01);
      drain("t1");
      check("t1_words", 72'(cyc_log.size()), 72'd4);
      for (int i = 0; i < 4 && i < cyc_log.size(); i++)
         check($sformatf("t1_cycle_%0d", i), 72'(cyc_log[i]), 72'(k0 + 3 + i));

      // T2: simultaneous packets alternate starting at port 0
      do_reset();
      for (int r = 0; r < 2; r++) begin
         fork
            send_pkt(0, 1, 1, 99, 0, 8'h00);
            send_pkt(1, 1, 1, 99, 0, 8'h00);
         join
         drain($sformatf("t2_r%0d", r));
      end
      check("t2_order_len", 72'(order_log.size()), 72'd4);
      for (int i = 0; i < 4 && i < order_log.size(); i++)
         check($sformatf("t2_order_%0d", i), 72'(order_log[i]), 72'(i % 2));

      // T3: out_rdy toggling during a 6-word packet
      fork
         send_pkt(0, 1, 4, 99, 0, 8'h00);
         for (int i = 0; i < 14; i++) begin
            if_out.rdy = (i % 2 == 0);
            @(negedge clk);
         end
      join
      if_out.rdy = 1'b1;
      drain("t3");

      // T4: port 0 stalls mid-packet while port 1 is ready
      order_log.delete();
      fork
         send_pkt(0, 1, 4, 3, 5, 8'h00);
         begin
            @(negedge clk);
            send_pkt(1, 1, 2, 99, 0, 8'h00);
         end
      join
      drain("t4");
      check("t4_order_len", 72'(order_log.size()), 72'd2);
      if (order_log.size() == 2) begin
         check("t4_first", 72'(order_log[0]), 72'd0);
         check("t4_second", 72'(order_log[1]), 72'd1);
      end

      // T5: backpressure fills port 1 FIFO; eighth word is the absorbed in-flight one
      if_out.rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0]  c;
         logic [63:0] d;
         c = (i == 0) ? 8'hFF : (i == 7) ? 8'h01 : 8'h00;
         d = {1'b1, seq[1][14:0], 16'(i), 32'($urandom())};
         check($sformatf("t5_rdy_%0d", i), 72'(if_1.rdy), 72'(i < 7));
         drive(1, 1'b1, c, d);
         push_exp(1, c, d);
         @(negedge clk);
      end
      drive(1, 1'b0, 8'h00, 64'h0);
      seq[1]++; exp_cnt[1]++;
      repeat (3) @(negedge clk);
      check("t5_rdy_full", 72'(if_1.rdy), 72'd0);
      if_out.rdy = 1'b1;
      drain("t5");

      // T6: reset in the middle of a port 1 packet
      for (int i = 0; i < 3; i++) begin
         logic [7:0]  c;
         logic [63:0] d;
         c = (i == 0) ? 8'hFF : 8'h00;
         d = {1'b1, seq[1][14:0], 16'(i), 32'($urandom())};
         drive(1, 1'b1, c, d);
         push_exp(1, c, d);
         @(negedge clk);
      end
      drive(1, 1'b0, 8'h00, 64'h0);
      seq[1]++;
      repeat (8) @(negedge clk);
      check("t6_partial_out", 72'(exp_q1.size()), 72'd0);
      reset = 1'b1;
      exp_q0.delete(); exp_q1.delete(); order_log.delete();
      @(posedge clk);
      #1;
      check("t6_out_wr", 72'(if_out.wr), 72'd0);
      check("t6_out_word", 72'({if_out.ctrl, if_out.data}), 72'd0);
      check("t6_cnt0", 72'(pkt_cnt_0), 72'd0);
      check("t6_cnt1", 72'(pkt_cnt_1), 72'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      @(negedge clk);
      check("t6_rdy0", 72'(if_0.rdy), 72'd1);
      check("t6_rdy1", 72'(if_1.rdy), 72'd1);
      send_pkt(0, 1, 2, 99, 0, 8'h01);
      drain("t6_p0");
      send_pkt(1, 1, 2, 99, 0, 8'h00);
      drain("t6_p1");

      // Randomized traffic on both ports with random backpressure
      rand_done = 0;
      fork
         begin
            fork
               for (int k = 0; k < 12; k++)
                  send_pkt(0, $urandom_range(1, 2), $urandom_range(1, 5),
                           $urandom_range(0, 9), $urandom_range(0, 4), 8'h00);
               for (int k = 0; k < 12; k++)
                  send_pkt(1, $urandom_range(1, 2), $urandom_range(1, 5),
                           $urandom_range(0, 9), $urandom_range(0, 4), 8'h00);
            join
            rand_done = 1;
         end
         while (!rand_done) begin
            if_out.rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      join
      if_out.rdy = 1'b1;
      drain("rand");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
